// File: rtl/intc_pkg.sv
// intc_pkg: register map and limits for the interrupt controller.
package intc_pkg;
  typedef enum logic [1:0] {
    INTC_PENDING = 2'd0,
    INTC_ENABLE  = 2'd1,
    INTC_CLAIM   = 2'd2,
    INTC_LEVEL   = 2'd3
  } intc_reg_e;
  localparam int INTC_MAX_SOURCES = 31;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-set-bit priority encoder.
module intc_prio_enc #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] index
);
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) begin
        valid = 1'b1;
        index = W'(i);
      end
  end
endmodule

// File: rtl/intc.sv
// intc: memory-mapped interrupt controller with edge/level sources and read-to-claim.
module intc
  import intc_pkg::*;
#(
  parameter int NUM_SOURCES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic                   rd,
  input  logic                   wr,
  input  intc_reg_e              addr,
  input  logic [31:0]            data_in,
  output logic [31:0]            data_out,
  input  logic [NUM_SOURCES-1:0] irq,
  output logic                   hwint
);
  localparam int N = NUM_SOURCES;
  localparam int W = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0] pending, enable, level, irq_q;
  logic [N-1:0] set, clr, claim_mask, pending_next, enable_next, level_next;
  logic [W-1:0] index;
  logic         valid, rd_act, wr_act, claim;
  logic [4:0]   id;
  intc_prio_enc #(.N(N)) u_enc (.vec(pending & enable), .valid(valid), .index(index));
  always_comb begin
    rd_act       = cs & rd;
    wr_act       = cs & wr;
    id           = valid ? 5'(index) + 5'd1 : 5'd0;
    claim        = rd_act & ~wr & (addr == INTC_CLAIM) & valid;
    claim_mask   = claim ? N'(1) << index : '0;
    clr          = (wr_act && addr == INTC_PENDING) ? data_in[N-1:0] | claim_mask : claim_mask;
    set          = (level & irq) | (~level & irq & ~irq_q);
    pending_next = (pending & ~clr) | set;
    enable_next  = (wr_act && addr == INTC_ENABLE) ? data_in[N-1:0] : enable;
    level_next   = (wr_act && addr == INTC_LEVEL) ? data_in[N-1:0] : level;
    data_out     = !rd_act               ? 32'd0 :
                   addr == INTC_PENDING  ? 32'(pending) :
                   addr == INTC_ENABLE   ? 32'(enable) :
                   addr == INTC_CLAIM    ? 32'(id) : 32'(level);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
      level   <= '0;
      irq_q   <= '0;
      hwint   <= 1'b0;
    end else begin
      pending <= pending_next;
      enable  <= enable_next;
      level   <= level_next;
      irq_q   <= irq;
      hwint   <= |(pending_next & enable_next);
    end
  end
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed test-plan sequences plus random traffic against a bit-level reference model.
module tb_intc;
  import intc_pkg::*;
  logic        clk = 1'b0, rst, cs, rd, wr, hwint;
  intc_reg_e   addr;
  logic [31:0] data_in, data_out, rdata;
  logic [7:0]  irq;
  bit   [7:0]  m_pend, m_en, m_lvl, m_irq_q;
  bit          m_hw;
  int          checks = 0, passed = 0;
  always #5 clk = ~clk;
  intc #(.NUM_SOURCES(8)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .irq(irq), .hwint(hwint)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask
  function automatic int model_id();
    for (int i = 0; i < 8; i++) if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction
  function automatic logic [31:0] model_read();
    if (!(cs && rd)) return 32'd0;
    case (addr)
      INTC_PENDING: return 32'(m_pend);
      INTC_ENABLE:  return 32'(m_en);
      INTC_CLAIM:   return 32'(model_id());
      default:      return 32'(m_lvl);
    endcase
  endfunction
  task automatic model_step();
    int id = model_id();
    bit [7:0] np = m_pend, ne = m_en, nl = m_lvl;
    if (rst) begin
      np = 0; ne = 0; nl = 0;
      m_irq_q = 0;
    end else begin
      if (cs && wr) begin
        if (addr == INTC_PENDING) np = np & ~data_in[7:0];
        if (addr == INTC_ENABLE) ne = data_in[7:0];
        if (addr == INTC_LEVEL) nl = data_in[7:0];
      end
      if (cs && rd && !wr && addr == INTC_CLAIM && id != 0) np[id-1] = 1'b0;
      for (int i = 0; i < 8; i++)
        if (m_lvl[i] ? irq[i] : (irq[i] && !m_irq_q[i])) np[i] = 1'b1;
      m_irq_q = irq;
    end
    m_pend = np; m_en = ne; m_lvl = nl;
    m_hw = |(np & ne);
  endtask
  task automatic cyc(input bit r, c, rr, w, input intc_reg_e a, input logic [31:0] d, input logic [7:0] q);
    rst = r; cs = c; rd = rr; wr = w; addr = a; data_in = d; irq = q;
    #1;
    rdata = data_out;
    check("data_out", rdata, model_read());
    model_step();
    @(posedge clk);
    #1;
    check("hwint", hwint, m_hw);
    @(negedge clk);
  endtask
  task automatic wr_reg(input intc_reg_e a, input logic [31:0] d, input logic [7:0] q);
    cyc(0, 1, 0, 1, a, d, q);
  endtask
  task automatic rd_reg(input intc_reg_e a, input logic [7:0] q);
    cyc(0, 1, 1, 0, a, 0, q);
  endtask
  initial begin
    rst = 1; cs = 0; rd = 0; wr = 0; addr = INTC_PENDING; data_in = 0; irq = 0;
    @(negedge clk);
    cyc(1, 1, 0, 1, INTC_ENABLE, 32'hFF, 8'hFF);
    cyc(1, 1, 0, 1, INTC_ENABLE, 32'hFF, 8'hFF);
    check("rst_hwint", hwint, 0);
    rd_reg(INTC_PENDING, 0); check("rst_pend", rdata, 0);
    rd_reg(INTC_ENABLE, 0);  check("rst_en", rdata, 0);
    rd_reg(INTC_LEVEL, 0);   check("rst_lvl", rdata, 0);
    wr_reg(INTC_ENABLE, 32'h08, 0);
    cyc(0, 0, 0, 0, INTC_PENDING, 0, 8'h08);
    check("edge_hwint", hwint, 1);
    rd_reg(INTC_PENDING, 0); check("edge_pend", rdata, 8'h08);
    rd_reg(INTC_CLAIM, 0);   check("edge_claim", rdata, 4);
    check("edge_hw_drop", hwint, 0);
    rd_reg(INTC_PENDING, 0); check("edge_pend_clr", rdata, 0);
    wr_reg(INTC_ENABLE, 32'hFF, 0);
    cyc(0, 0, 0, 0, INTC_PENDING, 0, 8'b1010_0100);
    rd_reg(INTC_CLAIM, 0); check("prio1", rdata, 3);
    rd_reg(INTC_CLAIM, 0); check("prio2", rdata, 6);
    rd_reg(INTC_CLAIM, 0); check("prio3", rdata, 8);
    check("prio_hw", hwint, 0);
    rd_reg(INTC_CLAIM, 0); check("prio4", rdata, 0);
    wr_reg(INTC_ENABLE, 0, 0);
    cyc(0, 0, 0, 0, INTC_PENDING, 0, 8'h01);
    rd_reg(INTC_PENDING, 0); check("mask_pend", rdata, 1);
    check("mask_hw", hwint, 0);
    wr_reg(INTC_ENABLE, 1, 0); check("unmask_hw", hwint, 1);
    rd_reg(INTC_CLAIM, 0);     check("unmask_claim", rdata, 1);
    wr_reg(INTC_LEVEL, 1, 0);
    wr_reg(INTC_ENABLE, 1, 0);
    cyc(0, 0, 0, 0, INTC_PENDING, 0, 8'h01);
    wr_reg(INTC_PENDING, 1, 8'h01); check("lvl_hw", hwint, 1);
    rd_reg(INTC_PENDING, 8'h01);    check("lvl_pend", rdata, 1);
    cyc(0, 0, 0, 0, INTC_PENDING, 0, 0);
    wr_reg(INTC_PENDING, 1, 0); check("lvl_hw_clr", hwint, 0);
    rd_reg(INTC_PENDING, 0);    check("lvl_pend_clr", rdata, 0);
    wr_reg(INTC_LEVEL, 0, 0);
    wr_reg(INTC_ENABLE, 32'hFF, 0);
    cyc(0, 0, 0, 0, INTC_PENDING, 0, 8'h06);
    cyc(0, 1, 1, 1, INTC_CLAIM, 32'hFF, 0); check("rw_claim", rdata, 2);
    rd_reg(INTC_PENDING, 0); check("rw_pend", rdata, 8'h06);
    cyc(1, 1, 1, 0, INTC_CLAIM, 0, 0);
    rd_reg(INTC_PENDING, 0); check("rst_mid_pend", rdata, 0);
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(39) == 0, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0,
          intc_reg_e'($urandom_range(3)), $urandom, 8'($urandom));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
